bp_fpga_host_uart_tx: RTL and testbench
=======================================

Name: bp_fpga_host_uart_tx

Overview:
UART transmit serializer for the FPGA host path. It consumes the byte stream produced by the host IO-out NBF serializer through a ready/valid handshake. It drives the physical UART TX line to the PC host as start bit, data bits LSB first, optional parity, then stop bits. It sits directly downstream of the NBF parallel-in-serial-out stage and is the final stage before the pin.

Parameters:
- clk_per_bit_p, 868: clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
- uart_data_bits_p, 8: data bits per frame; legal range 5..9.
- uart_parity_bits_p, 0: 0 = no parity, 1 = one parity bit.
- uart_parity_odd_p, 0: 0 = even parity, 1 = odd parity; ignored when uart_parity_bits_p = 0.
- uart_stop_bits_p, 1: stop bits per frame; legal values 1 or 2.

Ports:
- clk_i, input, 1: clock.
- reset_n_i, input, 1: reset; asynchronous, active-low.
- tx_i, input, uart_data_bits_p: byte to send; bit 0 is transmitted first.
- tx_v_i, input, 1: tx_i valid.
- tx_ready_and_o, output, 1: block accepts tx_i; a transfer occurs when tx_v_i & tx_ready_and_o.
- uart_tx_o, output, 1: serial line; idle/mark = 1.
- busy_o, output, 1: a frame is in progress (state != e_idle).

Behaviour:
- Clock, reset and handshake:
  - One clock (clk_i). Reset is asynchronous and active-low (reset_n_i).
  - While reset_n_i = 0: uart_tx_o = 1, tx_ready_and_o = 0, busy_o = 0, state = e_idle, all counters = 0, shift register = 0.
  - Handshake is ready-and-valid. tx_ready_and_o does not depend on tx_v_i. tx_i is captured into the shift register on the transfer cycle.
- Frame length: F = 1 + uart_data_bits_p + uart_parity_bits_p + uart_stop_bits_p bits. Each bit is held for exactly clk_per_bit_p cycles.
- States (enum):
  - e_idle: uart_tx_o = 1; tx_ready_and_o = 1. On transfer: capture data, compute parity, clear baud counter, go to e_start.
  - e_start: uart_tx_o = 0 for clk_per_bit_p cycles, then go to e_data with bit counter = 0.
  - e_data: uart_tx_o = shift_r[0]. At the end of each bit period, shift right and increment the bit counter. After uart_data_bits_p bits, go to e_parity if uart_parity_bits_p = 1, else e_stop.
  - e_parity: uart_tx_o = (^data) ^ uart_parity_odd_p. Lasts one bit period, then go to e_stop.
  - e_stop: uart_tx_o = 1 for uart_stop_bits_p bit periods.
    - tx_ready_and_o = 1 only in the final cycle of the last stop bit.
    - Transfer in that cycle: go directly to e_start, giving zero gap between frames.
    - No transfer in that cycle: go to e_idle.
- Timing:
  - Transfer in cycle t: the start bit occupies cycles t+1 .. t+clk_per_bit_p. Data bit k occupies cycles t+(k+1)*clk_per_bit_p+1 .. t+(k+2)*clk_per_bit_p.
  - Back-to-back throughput is exactly F*clk_per_bit_p cycles per byte.
- uart_tx_o and busy_o are registered outputs with no combinational path from inputs.
- Counters:
  - Baud counter width is `BSG_SAFE_CLOG2(clk_per_bit_p)`. It counts 0..clk_per_bit_p-1, wraps to 0, and raises a bit_done strobe at clk_per_bit_p-1.
  - Bit counter width is `BSG_SAFE_CLOG2(uart_data_bits_p+1)`.
- Parity is computed from the captured data, not from the shifting register.
- tx_i is only sampled on the transfer cycle; changes on tx_i mid-frame have no effect.
- If tx_v_i is low in e_idle, the line stays 1 indefinitely.
- Reset asserted mid-frame: the line immediately returns to 1 and the frame is truncated. After release the block starts in e_idle and the byte is not retransmitted.
- Illegal parameters (clk_per_bit_p < 2, data bits outside 5..9, stop bits not 1 or 2) fail an elaboration-time assertion.

Decomposition:
- bp_fpga_host_pkg gets:
  - the bp_fpga_host_uart_tx_state_e enum;
  - a default baud constant: clk_per_bit from a 100 MHz clock at 115200 baud.
- One natural sub-module: bp_fpga_host_uart_baud_tick, the baud counter with clear input and bit_done strobe. The bit reception side can reuse it later.
- Everything else stays inline.

Test Plan:
- Settings for all scenarios unless noted: clk_per_bit_p = 4, 8N1.
- Single byte: send 0x55 at cycle t. The line reads 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, starting at t+1. busy_o falls at t+41. tx_ready_and_o is high at t+40.
- Back-to-back: hold tx_v_i with 0x41 then 0x42. The second start bit begins exactly 40 cycles after the first, with no idle gap. Bytes decode correctly.
- Parity: with 8E1, 0x07 gives parity bit 1 and 0x03 gives parity bit 0. With 8O1, 0x07 gives parity bit 0. Each frame is 44 cycles.
- Stop bits and data width: with 7N2, send 0x7F. The stop level of 1 lasts 8 cycles and ready appears only in the last stop cycle.
- Reset mid-frame: assert reset_n_i = 0 asynchronously during data bit 3. uart_tx_o goes to 1 without a clock edge and ready = 0. After release, idle with ready = 1 next cycle. Then send 0xA5, which transmits cleanly.
- Handshake hygiene: tx_v_i = 0 for 100 cycles leaves the line constant 1. Changing tx_i mid-frame leaves the transmitted byte unchanged.

Source files
------------

// File: rtl/bp_fpga_host_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_fpga_host_pkg
//  Description : Shared types and constants for the FPGA host UART path.
//                Provides the UART TX state encoding, the default baud
//                divider, and a safe clog2 helper that never returns 0.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_fpga_host_pkg;

  // 100 MHz core clock at 115200 baud. Integer division gives 868.
  localparam int c_uart_clk_per_bit_default = 100_000_000 / 115_200;

  typedef enum logic [2:0] {
    e_idle   = 3'd0,
    e_start  = 3'd1,
    e_data   = 3'd2,
    e_parity = 3'd3,
    e_stop   = 3'd4
  } bp_fpga_host_uart_tx_state_e;

  // Counter width helper. A value of 1 still needs one bit of storage.
  function automatic int bsg_safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_fpga_host_uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : bp_fpga_host_uart_baud_tick
//  Description : Baud-period counter. Counts 0..clk_per_bit_p-1 while enabled
//                and wraps. bit_done_o strobes in the last cycle of each bit
//                period. clear_i restarts the period and wins over en_i.
//  Ports       : clk_i      - clock
//                reset_n_i  - asynchronous active-low reset
//                en_i       - count enable (a frame is in progress)
//                clear_i    - restart the bit period at 0
//                bit_done_o - last cycle of the current bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_fpga_host_uart_baud_tick
  import bp_fpga_host_pkg::*;
#(
  parameter int clk_per_bit_p = c_uart_clk_per_bit_default
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic en_i,
  input  logic clear_i,
  output logic bit_done_o
);

  localparam int                 c_cnt_w = bsg_safe_clog2(clk_per_bit_p);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(clk_per_bit_p - 1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (en_i) begin
      r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
    end
  end

  assign bit_done_o = en_i & (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/bp_fpga_host_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : bp_fpga_host_uart_tx
//  Description : UART transmit serializer. Accepts one data word per
//                ready/valid transfer and sends start bit, data LSB first,
//                optional parity and 1 or 2 stop bits. A new word can be
//                accepted in the last stop cycle, so back-to-back frames
//                have no idle gap.
//  Ports       : clk_i          - clock
//                reset_n_i      - asynchronous active-low reset
//                tx_i           - word to send, bit 0 first
//                tx_v_i         - tx_i valid
//                tx_ready_and_o - word accepted when tx_v_i is also high
//                uart_tx_o      - serial line, idle high (registered)
//                busy_o         - frame in progress (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_fpga_host_uart_tx
  import bp_fpga_host_pkg::*;
#(
  parameter int clk_per_bit_p      = c_uart_clk_per_bit_default,
  parameter int uart_data_bits_p   = 8,
  parameter int uart_parity_bits_p = 0,
  parameter int uart_parity_odd_p  = 0,
  parameter int uart_stop_bits_p   = 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [uart_data_bits_p-1:0] tx_i,
  input  logic                        tx_v_i,
  output logic                        tx_ready_and_o,
  output logic                        uart_tx_o,
  output logic                        busy_o
);

  if (clk_per_bit_p < 2) begin : g_bad_clk_per_bit
    $error("bp_fpga_host_uart_tx: clk_per_bit_p must be >= 2");
  end
  if (uart_data_bits_p < 5 || uart_data_bits_p > 9) begin : g_bad_data_bits
    $error("bp_fpga_host_uart_tx: uart_data_bits_p must be 5..9");
  end
  if (uart_stop_bits_p != 1 && uart_stop_bits_p != 2) begin : g_bad_stop_bits
    $error("bp_fpga_host_uart_tx: uart_stop_bits_p must be 1 or 2");
  end

  localparam int                     c_bit_cnt_w     = bsg_safe_clog2(uart_data_bits_p + 1);
  localparam logic [c_bit_cnt_w-1:0] c_last_data_bit = c_bit_cnt_w'(uart_data_bits_p - 1);
  localparam logic                   c_last_stop     = 1'(uart_stop_bits_p - 1);
  localparam logic                   c_parity_odd    = 1'(uart_parity_odd_p);

  bp_fpga_host_uart_tx_state_e r_state;
  logic [uart_data_bits_p-1:0] r_shift;
  logic [c_bit_cnt_w-1:0]      r_bit_cnt;
  logic                        r_stop_cnt;
  logic                        r_parity;
  logic                        r_tx;
  logic                        r_busy;
  logic                        r_rst_done;

  logic w_bit_done;
  logic w_ready;
  logic w_xfer;

  // r_rst_done keeps ready low while reset is held and until the first
  // clock after release, even though the state already reads e_idle.
  assign w_ready = r_rst_done &
                   ((r_state == e_idle) |
                    ((r_state == e_stop) & w_bit_done & (r_stop_cnt == c_last_stop)));
  assign w_xfer  = w_ready & tx_v_i;

  bp_fpga_host_uart_baud_tick #(
    .clk_per_bit_p (clk_per_bit_p)
  ) u_baud_tick (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .en_i       (r_state != e_idle),
    .clear_i    (w_xfer),
    .bit_done_o (w_bit_done)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= e_idle;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_xfer) begin
        // Transfers only happen from idle or the final stop cycle, so
        // both paths enter the start bit the same way.
        r_state  <= e_start;
        r_shift  <= tx_i;
        r_parity <= (^tx_i) ^ c_parity_odd;
        r_tx     <= 1'b0;
        r_busy   <= 1'b1;
      end else begin
        unique case (r_state)
          e_idle: begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
          end
          e_start: begin
            if (w_bit_done) begin
              r_state   <= e_data;
              r_bit_cnt <= '0;
              r_tx      <= r_shift[0];
            end
          end
          e_data: begin
            if (w_bit_done) begin
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == c_last_data_bit) begin
                if (uart_parity_bits_p == 1) begin
                  r_state <= e_parity;
                  r_tx    <= r_parity;
                end else begin
                  r_state    <= e_stop;
                  r_stop_cnt <= 1'b0;
                  r_tx       <= 1'b1;
                end
              end else begin
                r_tx <= r_shift[1];
              end
            end
          end
          e_parity: begin
            if (w_bit_done) begin
              r_state    <= e_stop;
              r_stop_cnt <= 1'b0;
              r_tx       <= 1'b1;
            end
          end
          e_stop: begin
            if (w_bit_done) begin
              if (r_stop_cnt == c_last_stop) begin
                r_state <= e_idle;
                r_busy  <= 1'b0;
              end else begin
                r_stop_cnt <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= e_idle;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_ready_and_o = w_ready;
  assign uart_tx_o      = r_tx;
  assign busy_o         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bp_fpga_host_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_fpga_host_uart_tx
//  Description : Self-checking bench for bp_fpga_host_uart_tx. Four instances
//                at 4 clocks per bit: 8N1, 8E1, 8O1 and 7N2. Frames are
//                checked bit period by bit period against hand-written
//                serial bit patterns (bit i of the pattern is the i-th bit
//                on the line, start bit at position 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_fpga_host_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tx_v    [4];
  logic [7:0] tx_data [4];
  logic       rdy     [4];
  logic       line    [4];
  logic       busy    [4];

  always #5 clk = ~clk;

  bp_fpga_host_uart_tx #(.clk_per_bit_p(CPB), .uart_data_bits_p(8), .uart_parity_bits_p(0),
                         .uart_parity_odd_p(0), .uart_stop_bits_p(1)) u_8n1 (
    .clk_i(clk), .reset_n_i(reset_n), .tx_i(tx_data[0]), .tx_v_i(tx_v[0]),
    .tx_ready_and_o(rdy[0]), .uart_tx_o(line[0]), .busy_o(busy[0]));

  bp_fpga_host_uart_tx #(.clk_per_bit_p(CPB), .uart_data_bits_p(8), .uart_parity_bits_p(1),
                         .uart_parity_odd_p(0), .uart_stop_bits_p(1)) u_8e1 (
    .clk_i(clk), .reset_n_i(reset_n), .tx_i(tx_data[1]), .tx_v_i(tx_v[1]),
    .tx_ready_and_o(rdy[1]), .uart_tx_o(line[1]), .busy_o(busy[1]));

  bp_fpga_host_uart_tx #(.clk_per_bit_p(CPB), .uart_data_bits_p(8), .uart_parity_bits_p(1),
                         .uart_parity_odd_p(1), .uart_stop_bits_p(1)) u_8o1 (
    .clk_i(clk), .reset_n_i(reset_n), .tx_i(tx_data[2]), .tx_v_i(tx_v[2]),
    .tx_ready_and_o(rdy[2]), .uart_tx_o(line[2]), .busy_o(busy[2]));

  bp_fpga_host_uart_tx #(.clk_per_bit_p(CPB), .uart_data_bits_p(7), .uart_parity_bits_p(0),
                         .uart_parity_odd_p(0), .uart_stop_bits_p(2)) u_7n2 (
    .clk_i(clk), .reset_n_i(reset_n), .tx_i(tx_data[3][6:0]), .tx_v_i(tx_v[3]),
    .tx_ready_and_o(rdy[3]), .uart_tx_o(line[3]), .busy_o(busy[3]));

  typedef struct {
    int         dut;
    logic [7:0] data;
    int         nbits;
    logic [11:0] bits;
    string      name;
  } vec_t;

  vec_t vecs [8];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic wait_ready(input int d);
    int n;
    n = 0;
    while (rdy[d] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (rdy[d] !== 1'b1) check("ready_timeout", 32'(rdy[d]), 32'd1);
  endtask

  // Sends one word, then scrambles tx_i every cycle of the frame while
  // tx_v is low; the line must still carry the captured word.
  task automatic run_frame(input int d, input logic [7:0] data, input int nbits,
                           input logic [11:0] bits, input string name);
    logic [3:0] seen;
    int         early;
    int         nbusy;
    early = 0;
    nbusy = 0;
    seen  = '0;
    wait_ready(d);
    tx_data[d] = data;
    tx_v[d]    = 1'b1;
    @(negedge clk);
    tx_v[d] = 1'b0;
    for (int k = 1; k <= nbits * CPB; k++) begin
      tx_data[d] = 8'($urandom);
      seen[(k - 1) % CPB] = line[d];
      if (k < nbits * CPB && rdy[d] === 1'b1) early++;
      if (busy[d] !== 1'b1) nbusy++;
      if (k % CPB == 0)
        check($sformatf("%s bit%0d", name, (k - 1) / CPB), {28'd0, seen},
              bits[(k - 1) / CPB] ? 32'hF : 32'h0);
      if (k == nbits * CPB) check({name, " last_stop_ready"}, 32'(rdy[d]), 32'd1);
      @(negedge clk);
    end
    check({name, " early_ready"}, early, 0);
    check({name, " busy_in_frame"}, nbusy, 0);
    check({name, " busy_after"}, 32'(busy[d]), 32'd0);
    check({name, " line_after"}, 32'(line[d]), 32'd1);
  endtask

  initial begin
    int         bad;
    logic [3:0] seen;
    logic [19:0] bb;

    vecs[0] = '{0, 8'h55, 10, 12'b00_1_01010101_0,   "8n1_55"};
    vecs[1] = '{0, 8'h80, 10, 12'b00_1_10000000_0,   "8n1_80"};
    vecs[2] = '{1, 8'h07, 11, 12'b0_1_1_00000111_0,  "8e1_07"};
    vecs[3] = '{1, 8'h03, 11, 12'b0_1_0_00000011_0,  "8e1_03"};
    vecs[4] = '{2, 8'h07, 11, 12'b0_1_0_00000111_0,  "8o1_07"};
    vecs[5] = '{2, 8'h00, 11, 12'b0_1_1_00000000_0,  "8o1_00"};
    vecs[6] = '{3, 8'h7F, 10, 12'b00_11_1111111_0,   "7n2_7f"};
    vecs[7] = '{3, 8'h2A, 10, 12'b00_11_0101010_0,   "7n2_2a"};

    reset_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      tx_v[d]    = 1'b0;
      tx_data[d] = 8'h00;
    end

    // Reset state on all instances.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst_line%0d", d),  32'(line[d]), 32'd1);
      check($sformatf("rst_ready%0d", d), 32'(rdy[d]),  32'd0);
      check($sformatf("rst_busy%0d", d),  32'(busy[d]), 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 4; d++) check($sformatf("post_rst_ready%0d", d), 32'(rdy[d]), 32'd1);

    // Idle with no valid: line stays high, ready stays high.
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tx_data[0] = 8'($urandom);
      if (line[0] !== 1'b1 || rdy[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
      @(negedge clk);
    end
    check("idle_100", bad, 0);

    for (int i = 0; i < 8; i++)
      run_frame(vecs[i].dut, vecs[i].data, vecs[i].nbits, vecs[i].bits, vecs[i].name);

    // Back-to-back: valid held high, second start bit 40 cycles after first.
    bb = {10'b1_01000010_0, 10'b1_01000001_0};
    wait_ready(0);
    tx_data[0] = 8'h41;
    tx_v[0]    = 1'b1;
    @(negedge clk);
    tx_data[0] = 8'h42;
    bad  = 0;
    seen = '0;
    for (int k = 1; k <= 80; k++) begin
      if (k == 41) tx_v[0] = 1'b0;
      if (k > 41) tx_data[0] = 8'($urandom);
      seen[(k - 1) % CPB] = line[0];
      if (busy[0] !== 1'b1) bad++;
      if (k % CPB == 0)
        check($sformatf("b2b bit%0d", (k - 1) / CPB), {28'd0, seen},
              bb[(k - 1) / CPB] ? 32'hF : 32'h0);
      if (k == 40) check("b2b ready_at_40", 32'(rdy[0]), 32'd1);
      if (k == 41) check("b2b ready_at_41", 32'(rdy[0]), 32'd0);
      @(negedge clk);
    end
    check("b2b busy_continuous", bad, 0);
    check("b2b busy_after", 32'(busy[0]), 32'd0);

    // Reset asserted between clock edges during data bit 3.
    wait_ready(0);
    tx_data[0] = 8'h00;
    tx_v[0]    = 1'b1;
    @(negedge clk);
    tx_v[0] = 1'b0;
    repeat (17) @(negedge clk);
    check("mid_rst pre_line", 32'(line[0]), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst line", 32'(line[0]), 32'd1);
    check("mid_rst ready", 32'(rdy[0]), 32'd0);
    check("mid_rst busy", 32'(busy[0]), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst ready_after", 32'(rdy[0]), 32'd1);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (line[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
      @(negedge clk);
    end
    check("mid_rst no_retx", bad, 0);
    run_frame(0, 8'hA5, 10, 12'b00_1_10100101_0, "8n1_a5_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
